encoder_8b10b: RTL and testbench

Streaming 8b/10b line encoder for the PCIe logical physical layer, the transmit-side counterpart of `decoder_10b8b`. It accepts one data byte per handshake, maps it to a 10-bit code group using the 5b/6b and 3b/4b tables, and tracks running disparity (RD) across symbols. It registers the code group together with the RD that selected it. The output uses a one-entry valid/ready stage so the serializer can apply backpressure without losing bytes or corrupting RD.

---
 rtl/encoder_8b10b_if.sv | 22 ++
 rtl/encoder_8b10b.sv | 142 ++++++++++++++
 tb/tb_encoder_8b10b.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_8b10b_if.sv
// Handshake bundle for the streaming 8b/10b encoder.
// master: byte source and code-group sink (the surrounding logic / bench).
// slave:  the encoder itself.
interface encoder_8b10b_if;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic [9:0] data_out;
   logic       valid_out;
   logic       ready_in;
   logic       rd;

   modport master (
      output data_in, valid_in, ready_in,
      input  ready_out, data_out, valid_out, rd
   );

   modport slave (
      input  data_in, valid_in, ready_in,
      output ready_out, data_out, valid_out, rd
   );
endinterface

// File: rtl/encoder_8b10b.sv
// Streaming 8b/10b line encoder with running-disparity tracking and a
// one-entry valid/ready output stage.
// Optional build macro: ENC_ALT7_EN selects the A7 alternate for D.x.7
// where the primary code would produce a run length of 5.
module encoder_8b10b (
   input  logic            clk,
   input  logic            rst,
   encoder_8b10b_if.slave  bus
);

   logic [9:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       rd_q, rd_d;
   logic       rd_cur_q, rd_cur_d;

   logic       accept;
   logic [4:0] edcba;
   logic [2:0] hgf;
   logic [5:0] raw6, code6;
   logic [3:0] raw4, code4;
   logic       bal6, bal4;
   logic       rd_mid, rd_fin;
   logic       alt7;

   // 5b/6b code at RD-; the RD+ form is the bitwise complement for every
   // unbalanced code and for D.7, and identical for all other balanced codes.
   function automatic logic [5:0] enc6_rdn(input logic [4:0] v);
      logic [5:0] c;
      case (v)
         5'd0:  c = 6'b100111;
         5'd1:  c = 6'b011101;
         5'd2:  c = 6'b101101;
         5'd3:  c = 6'b110001;
         5'd4:  c = 6'b110101;
         5'd5:  c = 6'b101001;
         5'd6:  c = 6'b011001;
         5'd7:  c = 6'b111000;
         5'd8:  c = 6'b111001;
         5'd9:  c = 6'b100101;
         5'd10: c = 6'b010101;
         5'd11: c = 6'b110100;
         5'd12: c = 6'b001101;
         5'd13: c = 6'b101100;
         5'd14: c = 6'b011100;
         5'd15: c = 6'b010111;
         5'd16: c = 6'b011011;
         5'd17: c = 6'b100011;
         5'd18: c = 6'b010011;
         5'd19: c = 6'b110010;
         5'd20: c = 6'b001011;
         5'd21: c = 6'b101010;
         5'd22: c = 6'b011010;
         5'd23: c = 6'b111010;
         5'd24: c = 6'b110011;
         5'd25: c = 6'b100110;
         5'd26: c = 6'b010110;
         5'd27: c = 6'b110110;
         5'd28: c = 6'b001110;
         5'd29: c = 6'b101110;
         5'd30: c = 6'b011110;
         default: c = 6'b101011;
      endcase
      return c;
   endfunction

   // 3b/4b code at RD-; alt7 swaps P7 (1110) for A7 (0111). The RD+ form is
   // the complement for unbalanced codes and for D.x.3.
   function automatic logic [3:0] enc4_rdn(input logic [2:0] v, input logic a7);
      logic [3:0] c;
      case (v)
         3'd0:    c = 4'b1011;
         3'd1:    c = 4'b1001;
         3'd2:    c = 4'b0101;
         3'd3:    c = 4'b1100;
         3'd4:    c = 4'b1101;
         3'd5:    c = 4'b1010;
         3'd6:    c = 4'b0110;
         default: c = a7 ? 4'b0111 : 4'b1110;
      endcase
      return c;
   endfunction

   assign accept        = bus.valid_in && bus.ready_out;
   assign bus.ready_out = !valid_q || bus.ready_in;
   assign bus.data_out  = data_q;
   assign bus.valid_out = valid_q;
   assign bus.rd        = rd_q;

   // Encode the incoming byte against rd_cur and compute the next output-stage state.
   always_comb begin
      edcba  = bus.data_in[4:0];
      hgf    = bus.data_in[7:5];

      raw6   = enc6_rdn(edcba);
      bal6   = ($countones(raw6) == 3);
      code6  = (rd_cur_q && (!bal6 || edcba == 5'd7)) ? ~raw6 : raw6;
      rd_mid = rd_cur_q ^ !bal6;

`ifdef ENC_ALT7_EN
      alt7 = (hgf == 3'd7) &&
             (rd_mid ? (edcba == 5'd11 || edcba == 5'd13 || edcba == 5'd14)
                     : (edcba == 5'd17 || edcba == 5'd18 || edcba == 5'd20));
`else
      alt7 = 1'b0;
`endif

      raw4   = enc4_rdn(hgf, alt7);
      bal4   = ($countones(raw4) == 2);
      code4  = (rd_mid && (!bal4 || hgf == 3'd3)) ? ~raw4 : raw4;
      rd_fin = rd_mid ^ !bal4;

      data_d   = data_q;
      rd_d     = rd_q;
      rd_cur_d = rd_cur_q;
      valid_d  = valid_q;

      if (accept) begin
         data_d   = {code6, code4};
         rd_d     = rd_cur_q;
         rd_cur_d = rd_fin;
         valid_d  = 1'b1;
      end else if (valid_q && bus.ready_in) begin
         valid_d  = 1'b0;
      end
   end

   // Output stage and running-disparity register; reset drops any pending symbol.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q   <= '0;
         valid_q  <= 1'b0;
         rd_q     <= 1'b0;
         rd_cur_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         valid_q  <= valid_d;
         rd_q     <= rd_d;
         rd_cur_q <= rd_cur_d;
      end
   end

endmodule

// File: tb/tb_encoder_8b10b.sv
// Scoreboard bench for encoder_8b10b: directed cases plus randomized
// stream with random backpressure against a table-driven reference model.
module tb_encoder_8b10b;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   encoder_8b10b_if bus ();

   encoder_8b10b dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Full 5b/6b and 3b/4b tables, both disparity columns.
   localparam logic [5:0] T6N [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   localparam logic [5:0] T6P [32] = '{
      6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
      6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
      6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
      6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
   localparam logic [3:0] T4N [8] = '{
      4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
   localparam logic [3:0] T4P [8] = '{
      4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};

   // Returns {rd_after, code10}.
   function automatic logic [10:0] ref_enc(input logic [7:0] b, input logic rd_in);
      logic [5:0] c6;
      logic [3:0] c4;
      logic       rm;
      logic       ro;
      c6 = rd_in ? T6P[b[4:0]] : T6N[b[4:0]];
      rm = ($countones(c6) == 3) ? rd_in : !rd_in;
      c4 = rm ? T4P[b[7:5]] : T4N[b[7:5]];
`ifdef ENC_ALT7_EN
      if (b[7:5] == 3'd7 && !rm && (b[4:0] == 5'd17 || b[4:0] == 5'd18 || b[4:0] == 5'd20))
         c4 = 4'b0111;
      if (b[7:5] == 3'd7 && rm && (b[4:0] == 5'd11 || b[4:0] == 5'd13 || b[4:0] == 5'd14))
         c4 = 4'b1000;
`endif
      ro = ($countones(c4) == 2) ? rm : !rm;
      return {ro, c6, c4};
   endfunction

   logic [10:0] sb[$];
   logic        m_valid;
   logic        m_rd;

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_out(input string name, input logic [9:0] exp_data, input logic exp_rd);
      n_checks++;
      if ({bus.valid_out, bus.rd, bus.data_out} !== {1'b1, exp_rd, exp_data}) begin
         n_fail++;
         $display("FAIL %s: got valid=%0b rd=%0b data=%b, expected valid=1 rd=%0b data=%b",
                  name, bus.valid_out, bus.rd, bus.data_out, exp_rd, exp_data);
      end
   endtask

   task automatic drive(input logic vin, input logic [7:0] d, input logic rin);
      logic        exp_ready;
      logic [10:0] r;
      @(negedge clk);
      bus.valid_in = vin;
      bus.data_in  = d;
      bus.ready_in = rin;
      #1;
      exp_ready = !m_valid || rin;
      check_bit("ready_out", bus.ready_out, exp_ready);
      check_bit("valid_out", bus.valid_out, m_valid);
      if (vin && exp_ready) begin
         r = ref_enc(d, m_rd);
         sb.push_back({m_rd, r[9:0]});
         m_rd    = r[10];
         m_valid = 1'b1;
      end else if (m_valid && rin) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic model_clear();
      sb.delete();
      m_valid = 1'b0;
      m_rd    = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b0;
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      bus.ready_in = 1'b1;
      #1;
      model_clear();
      n_checks++;
      if ({bus.valid_out, bus.rd, bus.data_out} !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_state: got valid=%0b rd=%0b data=%b, expected all zero",
                  bus.valid_out, bus.rd, bus.data_out);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Monitor: one time unit before each rising edge, pop and compare every consumed symbol.
   initial begin
      logic [10:0] e;
      forever begin
         @(negedge clk);
         #4;
         if (rst && bus.valid_out && bus.ready_in) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_underflow: got rd=%0b data=%b, expected no symbol", bus.rd, bus.data_out);
            end else begin
               e = sb.pop_front();
               if ({bus.rd, bus.data_out} !== e) begin
                  n_fail++;
                  $display("FAIL sb_symbol: got rd=%0b data=%b, expected rd=%0b data=%b",
                           bus.rd, bus.data_out, e[10], e[9:0]);
               end
            end
         end
      end
   end

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b0;
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      bus.ready_in = 1'b1;
      model_clear();

      // 0x00 twice from reset: both at RD-
      do_reset();
      drive(1'b1, 8'h00, 1'b1);
      drive(1'b1, 8'h00, 1'b1);
      check_out("d0_0_first", 10'b1001110100, 1'b0);
      drive(1'b0, 8'h00, 1'b1);
      check_out("d0_0_second", 10'b1001110100, 1'b0);

      // 0x03 back-to-back: RD flips to + then back to -
      do_reset();
      drive(1'b1, 8'h03, 1'b1);
      drive(1'b1, 8'h03, 1'b1);
      check_out("d3_0_first", 10'b1100011011, 1'b0);
      drive(1'b1, 8'h00, 1'b1);
      check_out("d3_0_second", 10'b1100010100, 1'b1);
      drive(1'b0, 8'h00, 1'b1);
      check_out("d3_0_final_rd", 10'b1001110100, 1'b0);

      // 0xBC then 0xE7, RD+ afterwards
      do_reset();
      drive(1'b1, 8'hBC, 1'b1);
      drive(1'b1, 8'hE7, 1'b1);
      check_out("d28_5", 10'b0011101010, 1'b0);
      drive(1'b1, 8'h00, 1'b1);
      check_out("d7_7", 10'b1110001110, 1'b0);
      drive(1'b0, 8'h00, 1'b1);
      check_out("d0_0_at_rdp", 10'b0110001011, 1'b1);

      // Backpressure: hold for 5 cycles, nothing accepted
      do_reset();
      drive(1'b1, 8'h00, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'h03, 1'b0);
         check_bit("bp_ready_low", bus.ready_out, 1'b0);
         check_out("bp_hold", 10'b1001110100, 1'b0);
      end
      drive(1'b1, 8'h03, 1'b1);
      drive(1'b0, 8'h00, 1'b1);
      check_out("bp_release", 10'b1100011011, 1'b0);

      // D.17.7 at RD-
      do_reset();
      drive(1'b1, 8'hF1, 1'b1);
      drive(1'b1, 8'h00, 1'b1);
`ifdef ENC_ALT7_EN
      check_out("d17_7", 10'b1000110111, 1'b0);
`else
      check_out("d17_7", 10'b1000111110, 1'b0);
`endif
      drive(1'b0, 8'h00, 1'b1);
      check_out("d17_7_rd_after", 10'b0110001011, 1'b1);

      // Asynchronous reset while a symbol is pending at RD+
      do_reset();
      drive(1'b1, 8'hF1, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      model_clear();
      n_checks++;
      if ({bus.valid_out, bus.rd, bus.data_out} !== 12'd0) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%0b rd=%0b data=%b, expected all zero",
                  bus.valid_out, bus.rd, bus.data_out);
      end
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b1);
      check_out("after_reset_rdn", 10'b1001110100, 1'b0);

      // Randomized stream with random backpressure
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1);

      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending symbols, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
